// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if : signal bundle between the CPU side, the SRAM controller and
//                the physical SRAM pads.
//
//   CPU side      : ADDR, Data_to_SRAM, OE (active-low), WE (active-low)
//                   in; Data_from_SRAM and the Ready pulse back to the CPU.
//   SRAM pad side : SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
//                   SRAM_DQ_out, SRAM_DQ_oe out; SRAM_DQ_in back in.
//
//   modport slave  : the controller's view.
//   modport master : the environment's view (CPU plus SRAM / pad logic).
// ---------------------------------------------------------------------------
interface sram_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic              OE;
    logic              WE;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              Ready;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic [DATA_W-1:0] SRAM_DQ_out;
    logic              SRAM_DQ_oe;
    logic [DATA_W-1:0] SRAM_DQ_in;

    modport slave (
        input  ADDR, Data_to_SRAM, OE, WE, SRAM_DQ_in,
        output Data_from_SRAM, Ready, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );

    modport master (
        output ADDR, Data_to_SRAM, OE, WE, SRAM_DQ_in,
        input  Data_from_SRAM, Ready, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl : turns each level-style CPU read/write request into exactly one
//             timed SRAM bus cycle with programmable wait states, then pulses
//             Ready for one cycle. A held strobe never re-triggers: the
//             controller waits for both strobes to be released first.
//
//   Clk     : system clock, rising edge.
//   Reset_n : asynchronous, active-low reset.
//   bus     : sram_ctrl_if.slave (CPU request/response and SRAM pad signals).
//
// All outputs are flops whose next value is decoded from the next state, so
// the strobes change on the same edge as the state and never glitch.
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    sram_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5,
        S_WAIT_REL = 3'd6
    } state_t;

    // The phase counter loads WAIT-1 and ends the phase at 0, so a phase
    // lasts exactly WAIT cycles and the counter never wraps.
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t            state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              ce_n_q,   ce_n_d;
    logic              oe_n_q,   oe_n_d;
    logic              we_n_q,   we_n_d;
    logic              dq_oe_q,  dq_oe_d;
    logic              ready_q,  ready_d;

    // Next-state, counter and datapath latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                // A write wins when both strobes are asserted together.
                if (!bus.WE) begin
                    addr_d  = bus.ADDR;
                    wdata_d = bus.Data_to_SRAM;
                    state_d = S_WR_SETUP;
                end else if (!bus.OE) begin
                    addr_d  = bus.ADDR;
                    cnt_d   = RD_LOAD;
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                // Capture on the last OE_N-low cycle, while the SRAM drives.
                if (cnt_q == 4'd0) begin
                    rdata_d = bus.SRAM_DQ_in;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_SETUP: begin
                cnt_d   = WR_LOAD;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_HOLD: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (bus.OE && bus.WE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the registered strobes line up
    // with the state they belong to.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            S_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_DONE: begin
                ready_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any cycle in flight at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            ready_q <= ready_d;
        end
    end

    assign bus.Data_from_SRAM = rdata_q;
    assign bus.Ready          = ready_q;
    assign bus.SRAM_ADDR      = addr_q;
    assign bus.SRAM_CE_N      = ce_n_q;
    assign bus.SRAM_OE_N      = oe_n_q;
    assign bus.SRAM_WE_N      = we_n_q;
    assign bus.SRAM_DQ_out    = wdata_q;
    assign bus.SRAM_DQ_oe     = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl : directed bench for sram_ctrl (RD_WAIT = WR_WAIT = 2) with a
//                small behavioural SRAM keyed on the low address byte.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    logic Clk = 1'b0;
    logic Reset_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus monitors, updated away from the active edge.
    int ready_cnt   = 0;
    int double_rdy  = 0;
    int oe_fall_cnt = 0;
    int contention  = 0;
    logic ready_prev = 1'b0;
    logic oe_n_prev  = 1'b1;

    logic [15:0] mem [0:255];

    sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: preload during reset, write while WE_N is low.
    always @(posedge Clk) begin
        if (!Reset_n) begin
            mem[8'h34] <= 16'hBEEF;
        end else if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_DQ_oe) begin
            mem[bus.SRAM_ADDR[7:0]] <= bus.SRAM_DQ_out;
        end
    end

    assign bus.SRAM_DQ_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? mem[bus.SRAM_ADDR[7:0]] : 16'h0000;

    always @(negedge Clk) begin
        if (bus.Ready) ready_cnt++;
        if (bus.Ready && ready_prev) double_rdy++;
        if (!bus.SRAM_OE_N && oe_n_prev) oe_fall_cnt++;
        if (bus.SRAM_DQ_oe && !bus.SRAM_OE_N) contention++;
        ready_prev = bus.Ready;
        oe_n_prev  = bus.SRAM_OE_N;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Counts edges from the request-sampling edge (edge 1) up to Ready.
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.Ready && n < limit);
    endtask

    int lat;
    int r0, o0;

    initial begin
        Reset_n = 1'b0;
        bus.ADDR = 16'h0000;
        bus.Data_to_SRAM = 16'h0000;
        bus.OE = 1'b1;
        bus.WE = 1'b1;
        repeat (3) tick();
        Reset_n = 1'b1;
        tick();

        // Reset in the middle of a write pulse.
        bus.ADDR = 16'h0042; bus.Data_to_SRAM = 16'hA5A5; bus.WE = 1'b0;
        tick();
        tick();
        chk("wr_pulse_before_reset", bus.SRAM_WE_N, 1'b0);
        Reset_n = 1'b0;
        #1;
        chk("rst_ce_n", bus.SRAM_CE_N, 1'b1);
        chk("rst_oe_n", bus.SRAM_OE_N, 1'b1);
        chk("rst_we_n", bus.SRAM_WE_N, 1'b1);
        chk("rst_dq_oe", bus.SRAM_DQ_oe, 1'b0);
        chk("rst_ready", bus.Ready, 1'b0);
        chk("rst_rdata", bus.Data_from_SRAM, 16'h0000);
        chk("rst_addr", bus.SRAM_ADDR, 16'h0000);
        bus.WE = 1'b1;
        tick();
        Reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_ce_n", bus.SRAM_CE_N, 1'b1);
        chk("idle_no_ready", ready_cnt, 0);

        // Read 0x1234; ADDR moves after the request is latched.
        bus.ADDR = 16'h1234; bus.OE = 1'b0;
        tick();
        chk("rd_addr", bus.SRAM_ADDR, 16'h1234);
        chk("rd_oe_n_c1", bus.SRAM_OE_N, 1'b0);
        chk("rd_ready_c1", bus.Ready, 1'b0);
        bus.ADDR = 16'hFFFF;
        tick();
        chk("rd_oe_n_c2", bus.SRAM_OE_N, 1'b0);
        chk("rd_addr_held", bus.SRAM_ADDR, 16'h1234);
        chk("rd_ready_c2", bus.Ready, 1'b0);
        tick();
        chk("rd_ready_edge3", bus.Ready, 1'b1);
        chk("rd_oe_n_done", bus.SRAM_OE_N, 1'b1);
        chk("rd_data", bus.Data_from_SRAM, 16'hBEEF);
        tick();
        chk("rd_ready_1cyc", bus.Ready, 1'b0);
        chk("rd_data_kept", bus.Data_from_SRAM, 16'hBEEF);
        bus.OE = 1'b1;
        repeat (2) tick();

        // Write 0xA5A5 to 0x0042; data input changes after latch.
        bus.ADDR = 16'h0042; bus.Data_to_SRAM = 16'hA5A5; bus.WE = 1'b0;
        tick();
        chk("wr_setup_we_n", bus.SRAM_WE_N, 1'b1);
        chk("wr_setup_ce_n", bus.SRAM_CE_N, 1'b0);
        chk("wr_setup_dq_oe", bus.SRAM_DQ_oe, 1'b1);
        chk("wr_setup_dq", bus.SRAM_DQ_out, 16'hA5A5);
        bus.Data_to_SRAM = 16'h0000;
        tick();
        chk("wr_pulse1_we_n", bus.SRAM_WE_N, 1'b0);
        tick();
        chk("wr_pulse2_we_n", bus.SRAM_WE_N, 1'b0);
        tick();
        chk("wr_hold_we_n", bus.SRAM_WE_N, 1'b1);
        chk("wr_hold_dq_oe", bus.SRAM_DQ_oe, 1'b1);
        chk("wr_hold_dq", bus.SRAM_DQ_out, 16'hA5A5);
        chk("wr_hold_ready", bus.Ready, 1'b0);
        tick();
        chk("wr_ready_edge5", bus.Ready, 1'b1);
        chk("wr_done_dq_oe", bus.SRAM_DQ_oe, 1'b0);
        chk("wr_done_ce_n", bus.SRAM_CE_N, 1'b1);
        bus.WE = 1'b1;
        repeat (2) tick();

        // Held read strobe of 0x0042: one cycle only, returns the write data.
        r0 = ready_cnt; o0 = oe_fall_cnt;
        bus.OE = 1'b0;
        repeat (20) tick();
        chk("held_ready_once", ready_cnt - r0, 1);
        chk("held_oe_once", oe_fall_cnt - o0, 1);
        chk("rd_after_wr", bus.Data_from_SRAM, 16'hA5A5);
        bus.OE = 1'b1;
        repeat (2) tick();
        bus.OE = 1'b0;
        wait_ready(10, lat);
        chk("rd_latency", lat, 3);
        chk("rd_again_data", bus.Data_from_SRAM, 16'hA5A5);
        bus.OE = 1'b1;
        repeat (2) tick();

        // Both strobes low: write wins, no read strobe, read data untouched.
        o0 = oe_fall_cnt;
        bus.ADDR = 16'h0010; bus.Data_to_SRAM = 16'h1357;
        bus.OE = 1'b0; bus.WE = 1'b0;
        wait_ready(12, lat);
        chk("both_latency", lat, 5);
        chk("both_no_oe", oe_fall_cnt - o0, 0);
        chk("both_rdata", bus.Data_from_SRAM, 16'hA5A5);
        bus.OE = 1'b1; bus.WE = 1'b1;
        repeat (2) tick();

        // Read back the simultaneous-strobe write.
        bus.ADDR = 16'h0010; bus.OE = 1'b0;
        wait_ready(10, lat);
        chk("rd2_latency", lat, 3);
        chk("rd2_data", bus.Data_from_SRAM, 16'h1357);
        bus.OE = 1'b1;
        repeat (2) tick();

        chk("no_contention", contention, 0);
        chk("no_double_ready", double_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
